can_selftest_sequencer: RTL and testbench

Synthesizable, parametrised round-robin self-test controller for a shared CAN bus of `NODES` SJA1000-compatible controllers. Each node takes a turn as sender and every other node must receive the frame. The block checks each step against bit-time-based timeouts and accumulates a saturating error count plus a per-node fail mask. It sits beside the controllers' host-side glue: it requests transmits and consumes tx/rx-complete strobes that the glue derives from the interrupt registers.

---
 rtl/can_selftest_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_can_selftest_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_selftest_sequencer.sv
// ---------------------------------------------------------------------------
// can_selftest_sequencer
//
// Round-robin self-test controller for a shared CAN bus of NODES controllers.
// Each node in turn is asked to transmit one frame; every other node must
// report reception. Each step is bounded by a bit-time-based timeout. Errors
// are summed into a saturating counter, and every implicated node is marked
// in a sticky fail mask.
//
// Ports
//   clk        : single clock
//   rst        : synchronous, active-high reset
//   start      : begins a run (sampled only in IDLE and DONE)
//   canbus_rx  : bus level, 1 = recessive
//   tx_done    : per-node one-cycle tx-complete strobe
//   rx_done    : per-node one-cycle rx-complete strobe
//   tx_req     : one-hot, one-cycle transmit request to the current sender
//   sender     : index of the current sender
//   busy       : run in progress (every state except IDLE and DONE)
//   finished   : run complete, held until the next start or reset
//   errors     : saturating error count
//   fail_mask  : sticky per-node fail flags
// ---------------------------------------------------------------------------
module can_selftest_sequencer #(
   parameter int NODES       = 5,
   parameter int ROUNDS      = 1,
   parameter int BIT_CLKS    = 20,
   parameter int SETTLE_BITS = 8,
   parameter int SOF_BITS    = 2,
   parameter int TX_BITS     = 170,
   parameter int RX_CLKS     = 100,
   parameter int GAP_CLKS    = 100,
   parameter int ERR_W       = 16,
   localparam int IDXW       = ($clog2(NODES) > 1) ? $clog2(NODES) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             canbus_rx,
   input  logic [NODES-1:0] tx_done,
   input  logic [NODES-1:0] rx_done,
   output logic [NODES-1:0] tx_req,
   output logic [IDXW-1:0]  sender,
   output logic             busy,
   output logic             finished,
   output logic [ERR_W-1:0] errors,
   output logic [NODES-1:0] fail_mask
);

   localparam int SETTLE_CLKS = SETTLE_BITS * BIT_CLKS;
   localparam int SOF_CLKS    = SOF_BITS * BIT_CLKS;
   localparam int TX_CLKS     = TX_BITS * BIT_CLKS;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int T_MAX = max2(max2(max2(SETTLE_CLKS, SOF_CLKS), max2(TX_CLKS, RX_CLKS)), GAP_CLKS);
   localparam int TMR_W = $clog2(T_MAX + 1);
   localparam int SUM_W = ERR_W + 5;
   localparam logic [SUM_W-1:0] ERR_MAX = {5'b0, {ERR_W{1'b1}}};

   typedef enum logic [3:0] {
      IDLE, SETTLE, CHKIDLE, REQ, WAIT_SOF, WAIT_TX, WAIT_RX, GAP, NEXT, DONE
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [IDXW-1:0]    sender_q, sender_d;
   logic [7:0]         round_q, round_d;
   logic [NODES-1:0]   seen_q, seen_d;
   logic [ERR_W-1:0]   errors_q, errors_d;
   logic [NODES-1:0]   fail_q, fail_d;
   logic [NODES-1:0]   tx_req_q, tx_req_d;
   logic               busy_q, finished_q;

   logic [NODES-1:0]   sender_oh;
   logic [NODES-1:0]   stray;
   logic [NODES-1:0]   seen_now;
   logic [NODES-1:0]   missing;
   logic [NODES-1:0]   blame;
   logic [4:0]         inc;
   logic               clr_run;
   logic [ERR_W-1:0]   err_base;
   logic [SUM_W-1:0]   err_sum;

   function automatic logic [4:0] popcount(input logic [NODES-1:0] v);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < NODES; i++) cnt = cnt + 5'(v[i]);
      return cnt;
   endfunction

   assign sender_oh = {{(NODES-1){1'b0}}, 1'b1} << sender_q;
   // Strobes that must not occur before the sender has completed its frame.
   assign stray     = (tx_done & ~sender_oh) | rx_done;
   assign seen_now  = seen_q | rx_done;
   assign missing   = ~seen_now & ~sender_oh;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      timer_d  = '0;
      sender_d = sender_q;
      round_d  = round_q;
      seen_d   = seen_q;
      tx_req_d = '0;
      inc      = '0;
      blame    = '0;
      clr_run  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               clr_run  = 1'b1;
               sender_d = '0;
               round_d  = '0;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (timer_q == TMR_W'(SETTLE_CLKS - 1)) state_d = CHKIDLE;
            else                                    timer_d = timer_q + 1'b1;
         end
         CHKIDLE: begin
            if (!canbus_rx) begin
               inc   = 5'd1;
               blame = sender_oh;
            end
            state_d = REQ;
         end
         REQ: begin
            tx_req_d = sender_oh;
            seen_d   = '0;
            state_d  = WAIT_SOF;
         end
         WAIT_SOF, WAIT_TX: begin
            if (|stray) begin
               inc   = 5'd1;
               blame = stray;
            end
            // Timer value N is the (N+1)-th cycle in the state, so a strobe
            // in cycle LIMIT still passes and the timeout wins one cycle later.
            if (state_q == WAIT_SOF && timer_q == TMR_W'(SOF_CLKS) ||
                state_q == WAIT_TX  && timer_q == TMR_W'(TX_CLKS)) begin
               inc     = inc + 5'd1;
               blame   = blame | sender_oh;
               state_d = GAP;
            end else if (state_q == WAIT_SOF && !canbus_rx) begin
               state_d = WAIT_TX;
            end else if (state_q == WAIT_TX && |(tx_done & sender_oh)) begin
               state_d = WAIT_RX;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WAIT_RX: begin
            seen_d = seen_now;
            if (timer_q == TMR_W'(RX_CLKS - 1)) begin
               inc     = popcount(missing) + 5'(|(seen_now & sender_oh));
               blame   = missing | (seen_now & sender_oh);
               state_d = GAP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         GAP: begin
            if (|(tx_done | rx_done)) begin
               inc   = 5'd1;
               blame = tx_done | rx_done;
            end
            if (timer_q == TMR_W'(GAP_CLKS - 1)) state_d = NEXT;
            else                                 timer_d = timer_q + 1'b1;
         end
         NEXT: begin
            if (sender_q == IDXW'(NODES - 1)) begin
               sender_d = '0;
               round_d  = round_q + 8'd1;
               state_d  = (round_q + 8'd1 == 8'(ROUNDS)) ? DONE : CHKIDLE;
            end else begin
               sender_d = sender_q + 1'b1;
               state_d  = CHKIDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Sum is kept wider than the counter so a multi-error cycle cannot wrap
      // before clamping; a saturated counter stays at the clamp value.
      err_base = clr_run ? '0 : errors_q;
      err_sum  = {5'b0, err_base} + {{ERR_W{1'b0}}, inc};
      errors_d = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
      fail_d   = (clr_run ? '0 : fail_q) | blame;
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         sender_q   <= '0;
         round_q    <= '0;
         seen_q     <= '0;
         errors_q   <= '0;
         fail_q     <= '0;
         tx_req_q   <= '0;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         sender_q   <= sender_d;
         round_q    <= round_d;
         seen_q     <= seen_d;
         errors_q   <= errors_d;
         fail_q     <= fail_d;
         tx_req_q   <= tx_req_d;
         busy_q     <= (state_d != IDLE) && (state_d != DONE);
         finished_q <= (state_d == DONE);
      end
   end

   assign tx_req    = tx_req_q;
   assign sender    = sender_q;
   assign busy      = busy_q;
   assign finished  = finished_q;
   assign errors    = errors_q;
   assign fail_mask = fail_q;

endmodule

// File: tb/tb_can_selftest_sequencer.sv
// ---------------------------------------------------------------------------
// tb_can_selftest_sequencer
//
// Drives a behavioural bus of N nodes with per-node fault knobs (mute, deaf,
// echo, gap spur, stuck-dominant bus). Expected tx_req order and final
// errors/fail_mask are derived per run from the fault knobs and queued; a
// monitor pops and compares whenever the DUT pulses tx_req or raises
// finished. A second instance with ERR_W=2 shares the stimulus to exercise
// saturation.
// ---------------------------------------------------------------------------
module tb_can_selftest_sequencer;

   localparam int N           = 5;
   localparam int ROUNDS      = 1;
   localparam int BIT_CLKS    = 4;
   localparam int SETTLE_BITS = 8;
   localparam int SOF_BITS    = 2;
   localparam int TX_BITS     = 170;
   localparam int RX_CLKS     = 40;
   localparam int GAP_CLKS    = 20;
   localparam int SOF_DLY     = 3;
   localparam int TX_DLY      = 200;
   localparam int RX_DLY      = 10;
   localparam int RUN_LIMIT   = 20000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         canbus_rx = 1'b1;
   logic [N-1:0] tx_done = '0;
   logic [N-1:0] rx_done = '0;

   logic [N-1:0] tx_req, tx_req2;
   logic [2:0]   sender, sender2;
   logic         busy, busy2, finished, finished2;
   logic [15:0]  errors;
   logic [1:0]   errors2;
   logic [N-1:0] fail_mask, fail_mask2;

   can_selftest_sequencer #(
      .NODES(N), .ROUNDS(ROUNDS), .BIT_CLKS(BIT_CLKS), .SETTLE_BITS(SETTLE_BITS),
      .SOF_BITS(SOF_BITS), .TX_BITS(TX_BITS), .RX_CLKS(RX_CLKS), .GAP_CLKS(GAP_CLKS),
      .ERR_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .canbus_rx(canbus_rx),
      .tx_done(tx_done), .rx_done(rx_done), .tx_req(tx_req), .sender(sender),
      .busy(busy), .finished(finished), .errors(errors), .fail_mask(fail_mask)
   );

   can_selftest_sequencer #(
      .NODES(N), .ROUNDS(ROUNDS), .BIT_CLKS(BIT_CLKS), .SETTLE_BITS(SETTLE_BITS),
      .SOF_BITS(SOF_BITS), .TX_BITS(TX_BITS), .RX_CLKS(RX_CLKS), .GAP_CLKS(GAP_CLKS),
      .ERR_W(2)
   ) dut_sat (
      .clk(clk), .rst(rst), .start(start), .canbus_rx(canbus_rx),
      .tx_done(tx_done), .rx_done(rx_done), .tx_req(tx_req2), .sender(sender2),
      .busy(busy2), .finished(finished2), .errors(errors2), .fail_mask(fail_mask2)
   );

   always #5 clk = ~clk;

   // Fault knobs
   logic [N-1:0] mute;      // node never transmits
   logic [N-1:0] deaf;      // node never reports reception of foreign frames
   logic [N-1:0] echo;      // sender also reports reception of its own frame
   int           spur_tgt[N]; // node that strobes rx_done in the gap after sender i, -1 none
   logic         stuck;     // bus held dominant for the whole run

   typedef struct {
      int           errs;
      int           errs_sat;
      logic [N-1:0] mask;
   } result_t;

   int      exp_send_q[$];
   result_t exp_res_q[$];

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: each sender turn costs a fixed number of errors given the knobs.
   task automatic expect_run();
      int           total;
      logic [N-1:0] m;
      result_t      r;
      total = 0;
      m     = '0;
      for (int rd = 0; rd < ROUNDS; rd++) begin
         for (int s = 0; s < N; s++) begin
            exp_send_q.push_back(s);
            if (stuck) begin total++; m[s] = 1'b1; end
            if (mute[s]) begin
               total++; m[s] = 1'b1;
            end else begin
               for (int d = 0; d < N; d++)
                  if (d != s && deaf[d]) begin total++; m[d] = 1'b1; end
               if (echo[s]) begin total++; m[s] = 1'b1; end
               if (spur_tgt[s] >= 0) begin total++; m[spur_tgt[s]] = 1'b1; end
            end
         end
      end
      r.errs     = (total > 65535) ? 65535 : total;
      r.errs_sat = (total > 3) ? 3 : total;
      r.mask     = m;
      exp_res_q.push_back(r);
   endtask

   // Behavioural bus: reacts to tx_req with SOF, tx_done and rx_done strobes.
   int cyc = 0, sof_at = -1, txd_at = -1, rxd_at = -1, spur_at = -1, cur = 0;
   initial begin
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (rst) begin
            sof_at = -1; txd_at = -1; rxd_at = -1; spur_at = -1;
         end else if (tx_req != '0) begin
            for (int i = 0; i < N; i++) if (tx_req[i]) cur = i;
            if (!mute[cur]) begin
               sof_at  = cyc + SOF_DLY;
               txd_at  = sof_at + TX_DLY;
               rxd_at  = txd_at + RX_DLY;
               spur_at = (spur_tgt[cur] >= 0) ? txd_at + RX_CLKS + GAP_CLKS / 2 : -1;
            end
         end
         tx_done = '0;
         rx_done = '0;
         if (cyc == txd_at) tx_done[cur] = 1'b1;
         if (cyc == rxd_at) begin
            for (int r = 0; r < N; r++) if (r != cur && !deaf[r]) rx_done[r] = 1'b1;
            if (echo[cur]) rx_done[cur] = 1'b1;
         end
         if (cyc == spur_at) rx_done[spur_tgt[cur]] = 1'b1;
         canbus_rx = !(stuck || (sof_at >= 0 && cyc >= sof_at && cyc < txd_at));
      end
   end

   // Monitor: pops expectations as the DUT presents tx_req pulses and results.
   logic    fin_prev = 1'b0;
   int      mon_s;
   result_t mon_r;
   initial begin
      forever begin
         @(posedge clk); #2;
         if (tx_req != '0) begin
            if (exp_send_q.size() == 0) begin
               check("tx_req_unexpected", 32'(tx_req), 0);
            end else begin
               mon_s = exp_send_q.pop_front();
               check("tx_req_onehot", 32'(tx_req), 32'(1) << mon_s);
               check("sender_idx", 32'(sender), mon_s);
               check("busy_in_run", 32'(busy), 1);
            end
         end
         if (finished && !fin_prev) begin
            if (exp_res_q.size() == 0) begin
               check("finished_unexpected", 32'(finished), 0);
            end else begin
               mon_r = exp_res_q.pop_front();
               check("errors", 32'(errors), mon_r.errs);
               check("fail_mask", 32'(fail_mask), 32'(mon_r.mask));
               check("errors_sat", 32'(errors2), mon_r.errs_sat);
               check("fail_mask_sat", 32'(fail_mask2), 32'(mon_r.mask));
               check("busy_done", 32'(busy), 0);
            end
         end
         fin_prev = finished;
      end
   end

   task automatic clear_knobs();
      mute  = '0;
      deaf  = '0;
      echo  = '0;
      stuck = 1'b0;
      for (int i = 0; i < N; i++) spur_tgt[i] = -1;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_case(input string tag);
      int k;
      expect_run();
      pulse_start();
      k = 0;
      while (!finished && k < RUN_LIMIT) begin
         @(posedge clk); #3;
         k++;
      end
      check({tag, "_finished"}, 32'(finished), 1);
      @(posedge clk); #3;
      check({tag, "_drained"}, exp_send_q.size() + exp_res_q.size(), 0);
      exp_send_q.delete();
      exp_res_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_req"}, 32'(tx_req | tx_req2), 0);
      check({tag, "_sender"}, 32'(sender), 0);
      check({tag, "_busy"}, 32'(busy | busy2), 0);
      check({tag, "_finished"}, 32'(finished | finished2), 0);
      check({tag, "_errors"}, 32'(errors), 0);
      check({tag, "_fail_mask"}, 32'(fail_mask | fail_mask2), 0);
   endtask

   initial begin
      clear_knobs();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);

      run_case("ideal");

      clear_knobs(); mute[2] = 1'b1;
      run_case("mute2");

      clear_knobs(); deaf[3] = 1'b1;
      run_case("deaf3");

      clear_knobs(); stuck = 1'b1;
      run_case("stuck");

      clear_knobs(); spur_tgt[0] = 1;
      run_case("gap_spur");

      // Reset in the middle of the first sender's WAIT_TX.
      clear_knobs();
      begin
         int k;
         expect_run();
         pulse_start();
         k = 0;
         while (tx_req == '0 && k < 1000) begin
            @(posedge clk); #3;
            k++;
         end
         check("mid_reset_saw_req", 32'(tx_req != '0), 1);
         repeat (50) @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk); #1;
         check_reset_outputs("mid_reset");
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         exp_send_q.delete();
         exp_res_q.delete();
      end
      run_case("after_reset");

      for (int it = 0; it < 6; it++) begin
         clear_knobs();
         mute  = N'($urandom) & N'($urandom) & N'($urandom);
         deaf  = N'($urandom) & N'($urandom);
         echo  = N'($urandom) & N'($urandom);
         stuck = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++)
            spur_tgt[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
         run_case($sformatf("rand%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
